// File: rtl/multicycle_controller.sv
// Main sequencing FSM for the multicycle RV32I core: drives datapath enables/selects,
// stalls on the memory handshake, traps on unsupported opcodes and counts retirements.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | register read, branch target into ALUOut
// MEMADR   | compute load/store address
// MEMREAD  | load data access, wait for mem_ready
// MEMWB    | write loaded data to register file
// MEMWRITE | store data access, wait for mem_ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to register file
// BRANCH   | compare and conditionally redirect PC (BEQ/BNE)
// JALR     | compute rs1+imm target into ALUOut
// JAL      | PC <= target, link value PC+4 into ALUOut
// UPPER    | LUI/AUIPC result into ALUOut
// TRAP     | unsupported instruction, parked until reset
`timescale 1ns/1ps
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ALUOp,
  output logic [2:0]       dec_funct3,
  output logic             illegal,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JALR     = 4'd10,
    JAL      = 4'd11,
    UPPER    = 4'd12,
    TRAP     = 4'd13
  } state_t;

  state_t state, state_next;
  logic   pc_en, ir_en, mem_wr, reg_wr, retire;
  logic   unused_funct7b5;

  // funct7b5 goes straight to the ALU decoder; the FSM never looks at it
  assign unused_funct7b5 = funct7b5;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    retire     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    dec_funct3 = funct3;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_en     = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_next = MEMADR;
          7'b0110011:             state_next = EXECR;
          7'b0010011:             state_next = EXECI;
          7'b1100011:             state_next = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
          7'b1101111:             state_next = JAL;
          7'b1100111:             state_next = JALR;
          7'b0110111, 7'b0010111: state_next = UPPER;
          default:                state_next = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        reg_wr     = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_wr     = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_en      = zero ^ funct3[0];
        retire     = 1'b1;
        state_next = FETCH;
      end
      JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = JAL;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_en      = 1'b1;
        state_next = ALUWB;
      end
      UPPER: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b11;
        dec_funct3 = op[5] ? 3'b001 : 3'b000;
        state_next = ALUWB;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: state_next = TRAP;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  // enables are held off while reset is asserted, even mid-instruction
  assign PCWrite   = rst_n & pc_en;
  assign IRWrite   = rst_n & ir_en;
  assign MemWrite  = rst_n & mem_wr;
  assign RegWrite  = rst_n & reg_wr;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller: per-cycle state, control bundle,
// ImmSrc and instret checks, plus hand-written trap/reset sequences.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_JALR = 10, S_JAL = 11, S_UPPER = 12, S_TRAP = 13;

  logic        clk = 1'b0;
  logic        rst_n, funct7b5, zero, mem_ready;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc, dec_funct3;
  logic [3:0]  state_dbg;
  logic [31:0] instret;
  logic [16:0] act_ctl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs[$];

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUOp(ALUOp), .dec_funct3(dec_funct3), .illegal(illegal),
    .state_dbg(state_dbg), .instret(instret)
  );

  always #5 clk = ~clk;

  assign act_ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUOp, dec_funct3, illegal};

  // control bundle: {pcw,adr,mw,irw,rw,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,dec_funct3,illegal}
  function automatic logic [16:0] c(int pcw, int adr, int mw, int irw, int rw, int rs,
                                    int sa, int sb, int aop, int df3, int ill);
    return {1'(pcw), 1'(adr), 1'(mw), 1'(irw), 1'(rw), 2'(rs), 2'(sa), 2'(sb),
            2'(aop), 3'(df3), 1'(ill)};
  endfunction

  function automatic logic [2:0] exp_imm(logic [6:0] o);
    case (o)
      OP_SW:          return 3'd1;
      OP_BR:          return 3'd2;
      OP_JAL:         return 3'd3;
      OP_LUI, OP_AUI: return 3'd4;
      default:        return 3'd0;
    endcase
  endfunction

  task automatic add(int rst, logic [6:0] o, int f3, int z, int rdy, int st,
                     logic [16:0] ctl, int ir);
    vec_t v;
    v.rst = 1'(rst); v.op = o; v.f3 = 3'(f3); v.z = 1'(z); v.rdy = 1'(rdy);
    v.st = 4'(st); v.ctl = ctl; v.ir = 32'(ir);
    vecs.push_back(v);
  endtask

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  // drive at the falling edge, compare 1ns later; the rising edge then advances the FSM
  task automatic step(vec_t v, int idx);
    @(negedge clk);
    rst_n = v.rst; op = v.op; funct3 = v.f3; zero = v.z; mem_ready = v.rdy;
    #1;
    chk("state", idx, 32'(state_dbg), 32'(v.st));
    chk("ctrl", idx, 32'(act_ctl), 32'(v.ctl));
    chk("immsrc", idx, 32'(ImmSrc), 32'(exp_imm(v.op)));
    chk("instret", idx, instret, v.ir);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; op = OP_R; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // reset held: FETCH selects, all enables forced low
    add(0, OP_R, 0, 0, 1, S_FETCH,  c(0,0,0,0,0,2,0,2,0,0,0), 0);
    // add
    add(1, OP_R, 0, 0, 1, S_FETCH,  c(1,0,0,1,0,2,0,2,0,0,0), 0);
    add(1, OP_R, 0, 0, 1, S_DECODE, c(0,0,0,0,0,0,1,1,0,0,0), 0);
    add(1, OP_R, 0, 0, 1, S_EXECR,  c(0,0,0,0,0,0,2,0,2,0,0), 0);
    add(1, OP_R, 0, 0, 1, S_ALUWB,  c(0,0,0,0,1,0,0,0,0,0,0), 0);
    // slti with one fetch stall
    add(1, OP_I, 2, 0, 0, S_FETCH,  c(0,0,0,0,0,2,0,2,0,2,0), 1);
    add(1, OP_I, 2, 0, 1, S_FETCH,  c(1,0,0,1,0,2,0,2,0,2,0), 1);
    add(1, OP_I, 2, 0, 1, S_DECODE, c(0,0,0,0,0,0,1,1,0,2,0), 1);
    add(1, OP_I, 2, 0, 1, S_EXECI,  c(0,0,0,0,0,0,2,1,2,2,0), 1);
    add(1, OP_I, 2, 0, 1, S_ALUWB,  c(0,0,0,0,1,0,0,0,0,2,0), 1);
    // lw with three not-ready cycles in MEMREAD
    add(1, OP_LW, 2, 0, 1, S_FETCH,   c(1,0,0,1,0,2,0,2,0,2,0), 2);
    add(1, OP_LW, 2, 0, 1, S_DECODE,  c(0,0,0,0,0,0,1,1,0,2,0), 2);
    add(1, OP_LW, 2, 0, 1, S_MEMADR,  c(0,0,0,0,0,0,2,1,0,2,0), 2);
    add(1, OP_LW, 2, 0, 0, S_MEMREAD, c(0,1,0,0,0,0,0,0,0,2,0), 2);
    add(1, OP_LW, 2, 0, 0, S_MEMREAD, c(0,1,0,0,0,0,0,0,0,2,0), 2);
    add(1, OP_LW, 2, 0, 0, S_MEMREAD, c(0,1,0,0,0,0,0,0,0,2,0), 2);
    add(1, OP_LW, 2, 0, 1, S_MEMREAD, c(0,1,0,0,0,0,0,0,0,2,0), 2);
    add(1, OP_LW, 2, 0, 1, S_MEMWB,   c(0,0,0,0,1,1,0,0,0,2,0), 2);
    // sw with one not-ready cycle in MEMWRITE
    add(1, OP_SW, 2, 0, 1, S_FETCH,    c(1,0,0,1,0,2,0,2,0,2,0), 3);
    add(1, OP_SW, 2, 0, 1, S_DECODE,   c(0,0,0,0,0,0,1,1,0,2,0), 3);
    add(1, OP_SW, 2, 0, 1, S_MEMADR,   c(0,0,0,0,0,0,2,1,0,2,0), 3);
    add(1, OP_SW, 2, 0, 0, S_MEMWRITE, c(0,1,1,0,0,0,0,0,0,2,0), 3);
    add(1, OP_SW, 2, 0, 1, S_MEMWRITE, c(0,1,1,0,0,0,0,0,0,2,0), 3);
    // beq taken
    add(1, OP_BR, 0, 1, 1, S_FETCH,  c(1,0,0,1,0,2,0,2,0,0,0), 4);
    add(1, OP_BR, 0, 1, 1, S_DECODE, c(0,0,0,0,0,0,1,1,0,0,0), 4);
    add(1, OP_BR, 0, 1, 1, S_BRANCH, c(1,0,0,0,0,0,2,0,1,0,0), 4);
    // bne with zero=1: not taken
    add(1, OP_BR, 1, 1, 1, S_FETCH,  c(1,0,0,1,0,2,0,2,0,1,0), 5);
    add(1, OP_BR, 1, 1, 1, S_DECODE, c(0,0,0,0,0,0,1,1,0,1,0), 5);
    add(1, OP_BR, 1, 1, 1, S_BRANCH, c(0,0,0,0,0,0,2,0,1,1,0), 5);
    // jal
    add(1, OP_JAL, 0, 0, 1, S_FETCH,  c(1,0,0,1,0,2,0,2,0,0,0), 6);
    add(1, OP_JAL, 0, 0, 1, S_DECODE, c(0,0,0,0,0,0,1,1,0,0,0), 6);
    add(1, OP_JAL, 0, 0, 1, S_JAL,    c(1,0,0,0,0,0,1,2,0,0,0), 6);
    add(1, OP_JAL, 0, 0, 1, S_ALUWB,  c(0,0,0,0,1,0,0,0,0,0,0), 6);
    // jalr
    add(1, OP_JR, 0, 0, 1, S_FETCH,  c(1,0,0,1,0,2,0,2,0,0,0), 7);
    add(1, OP_JR, 0, 0, 1, S_DECODE, c(0,0,0,0,0,0,1,1,0,0,0), 7);
    add(1, OP_JR, 0, 0, 1, S_JALR,   c(0,0,0,0,0,0,2,1,0,0,0), 7);
    add(1, OP_JR, 0, 0, 1, S_JAL,    c(1,0,0,0,0,0,1,2,0,0,0), 7);
    add(1, OP_JR, 0, 0, 1, S_ALUWB,  c(0,0,0,0,1,0,0,0,0,0,0), 7);
    // lui: funct3 field is immediate bits, override to 001 in UPPER
    add(1, OP_LUI, 3, 0, 1, S_FETCH,  c(1,0,0,1,0,2,0,2,0,3,0), 8);
    add(1, OP_LUI, 3, 0, 1, S_DECODE, c(0,0,0,0,0,0,1,1,0,3,0), 8);
    add(1, OP_LUI, 3, 0, 1, S_UPPER,  c(0,0,0,0,0,0,1,1,3,1,0), 8);
    add(1, OP_LUI, 3, 0, 1, S_ALUWB,  c(0,0,0,0,1,0,0,0,0,3,0), 8);
    // auipc: override to 000
    add(1, OP_AUI, 5, 0, 1, S_FETCH,  c(1,0,0,1,0,2,0,2,0,5,0), 9);
    add(1, OP_AUI, 5, 0, 1, S_DECODE, c(0,0,0,0,0,0,1,1,0,5,0), 9);
    add(1, OP_AUI, 5, 0, 1, S_UPPER,  c(0,0,0,0,0,0,1,1,3,0,0), 9);
    add(1, OP_AUI, 5, 0, 1, S_ALUWB,  c(0,0,0,0,1,0,0,0,0,5,0), 9);
    // lw interrupted by reset in MEMREAD
    add(1, OP_LW, 2, 0, 1, S_FETCH,   c(1,0,0,1,0,2,0,2,0,2,0), 10);
    add(1, OP_LW, 2, 0, 1, S_DECODE,  c(0,0,0,0,0,0,1,1,0,2,0), 10);
    add(1, OP_LW, 2, 0, 1, S_MEMADR,  c(0,0,0,0,0,0,2,1,0,2,0), 10);
    add(0, OP_LW, 2, 0, 1, S_MEMREAD, c(0,1,0,0,0,0,0,0,0,2,0), 10);
    // resumes from FETCH with a cleared counter
    add(1, OP_R, 0, 0, 1, S_FETCH,  c(1,0,0,1,0,2,0,2,0,0,0), 0);
    add(1, OP_R, 0, 0, 1, S_DECODE, c(0,0,0,0,0,0,1,1,0,0,0), 0);
    add(1, OP_R, 0, 0, 1, S_EXECR,  c(0,0,0,0,0,0,2,0,2,0,0), 0);
    add(1, OP_R, 0, 0, 1, S_ALUWB,  c(0,0,0,0,1,0,0,0,0,0,0), 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // unsupported opcode: parks in TRAP, ignores mem_ready, instret frozen at 1
    v = '{1, OP_BAD, 3'd6, 0, 1, 4'(S_FETCH), c(1,0,0,1,0,2,0,2,0,6,0), 1};
    step(v, 100);
    v = '{1, OP_BAD, 3'd6, 0, 1, 4'(S_DECODE), c(0,0,0,0,0,0,1,1,0,6,0), 1};
    step(v, 101);
    for (int i = 0; i < 12; i++) begin
      v = '{1, OP_BAD, 3'd6, 1'(i), 1'(i + 1), 4'(S_TRAP), c(0,0,0,0,0,0,0,0,0,6,1), 1};
      step(v, 102 + i);
    end
    v = '{0, OP_BAD, 3'd6, 0, 1, 4'(S_TRAP), c(0,0,0,0,0,0,0,0,0,6,1), 1};
    step(v, 120);

    // branch with unsupported funct3 traps too
    v = '{1, OP_BR, 3'd4, 1, 1, 4'(S_FETCH), c(1,0,0,1,0,2,0,2,0,4,0), 0};
    step(v, 121);
    v = '{1, OP_BR, 3'd4, 1, 1, 4'(S_DECODE), c(0,0,0,0,0,0,1,1,0,4,0), 0};
    step(v, 122);
    for (int i = 0; i < 3; i++) begin
      v = '{1, OP_BR, 3'd4, 1, 1, 4'(S_TRAP), c(0,0,0,0,0,0,0,0,0,4,1), 0};
      step(v, 123 + i);
    end
    v = '{0, OP_BR, 3'd4, 1, 1, 4'(S_TRAP), c(0,0,0,0,0,0,0,0,0,4,1), 0};
    step(v, 126);
    v = '{1, OP_R, 3'd0, 0, 0, 4'(S_FETCH), c(0,0,0,0,0,2,0,2,0,0,0), 0};
    step(v, 127);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
